// File: rtl/camera_timing_pkg.sv
// Shared definitions for the camera timing sequencer.
// Contents: the frame state enumeration, the output levels driven while idle,
// and the minimum legal phase lengths used by the configuration check.
package camera_timing_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST     = 3'd1,
        EXPOSE  = 3'd2,
        SAMPLE  = 3'd3,
        HOLD    = 3'd4,
        READOUT = 3'd5,
        GAP     = 3'd6,
        DONE    = 3'd7
    } state_t;

    // Strobe levels held whenever no frame is in progress.
    localparam logic IDLE_VRST_SEL0  = 1'b1;
    localparam logic IDLE_PIXEL_RST  = 1'b0;
    localparam logic IDLE_PRECHARGE  = 1'b0;
    localparam logic IDLE_SAMPLE     = 1'b0;
    localparam logic IDLE_MEM_SEL    = 1'b0;
    localparam logic IDLE_PULSE      = 1'b1;

    // The reset phase needs a distinct first, middle and last cycle.
    localparam int MIN_RST_LEN     = 3;
    localparam int MIN_READOUT_LEN = 1;

endpackage

// File: rtl/phase_counter.sv
// Loadable down counter that times one sequencer phase.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (count clears to 0)
//   load        - load load_val on the next edge (wins over counting)
//   load_val    - phase length minus one
//   count_nxt   - value the counter takes on the next edge
//   tc          - terminal count: current value is zero
// The counter saturates at zero instead of wrapping.
module phase_counter #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count_nxt,
    output logic             tc
);

    logic [CNT_W-1:0] count_r;

    // Next count: load, otherwise decrement and hold at zero.
    always_comb begin
        count_nxt = count_r;
        if (load) begin
            count_nxt = load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_nxt = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_nxt = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nxt;
        end
    end

    assign tc = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/camera_timing_seq.sv
// Pixel-array timing sequencer: reset, exposure, sample, hold, row readout.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   start, continuous - frame request (taken in IDLE only), back-to-back mode
//   abort             - synchronous stop back to IDLE
//   rst_len, exposure, readout_len - phase lengths, latched at frame start
//   vrst_sel0, pixel_rst, precharge, sample, mem_sel, pulse - pixel strobes
//   row_select        - one-hot row enable during readout
//   busy, frame_done, cfg_err - status (frame_done / cfg_err are 1-cycle pulses)
// Every output is registered from the next state and next phase count, so the
// strobes line up exactly with the state they describe.
module camera_timing_seq
    import camera_timing_pkg::*;
#(
    parameter int CNT_W      = 14,
    parameter int NUM_ROWS   = 8,
    parameter int SAMPLE_LEN = 10,
    parameter int PRE_LEAD   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                continuous,
    input  logic                abort,
    input  logic [CNT_W-1:0]    rst_len,
    input  logic [CNT_W-1:0]    exposure,
    input  logic [CNT_W-1:0]    readout_len,
    output logic                vrst_sel0,
    output logic                pixel_rst,
    output logic                precharge,
    output logic                sample,
    output logic                mem_sel,
    output logic                pulse,
    output logic [NUM_ROWS-1:0] row_select,
    output logic                busy,
    output logic                frame_done,
    output logic                cfg_err
);

    localparam int               ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    state_t              state_r, state_nxt_s;
    logic [ROW_W-1:0]    row_r, row_nxt_s;
    logic [CNT_W-1:0]    cfg_rst_len_r, cfg_exposure_r, cfg_readout_len_r;
    logic [CNT_W-1:0]    cnt_nxt_s, cnt_load_val_s, rst_len_eff_s;
    logic                cnt_load_s, cnt_tc_s, cfg_valid_s, latch_s, cfg_err_nxt_s;
    logic [NUM_ROWS-1:0] row_select_nxt_s;

    phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load_s),
        .load_val  (cnt_load_val_s),
        .count_nxt (cnt_nxt_s),
        .tc        (cnt_tc_s)
    );

    assign cfg_valid_s = (rst_len >= CNT_W'(MIN_RST_LEN)) &&
                         (exposure > CNT_W'(PRE_LEAD)) &&
                         (readout_len >= CNT_W'(MIN_READOUT_LEN));

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt_s    = state_r;
        row_nxt_s      = row_r;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = CNT_ZERO;
        latch_s        = 1'b0;
        cfg_err_nxt_s  = 1'b0;
        if (abort && (state_r != IDLE)) begin
            state_nxt_s = IDLE;
            cnt_load_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // DONE always leaves; IDLE leaves only on start.
                    if ((state_r == IDLE) ? start : continuous) begin
                        if (cfg_valid_s) begin
                            state_nxt_s    = RST;
                            cnt_load_s     = 1'b1;
                            cnt_load_val_s = rst_len - CNT_ONE;
                            latch_s        = 1'b1;
                        end else begin
                            state_nxt_s   = IDLE;
                            cfg_err_nxt_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RST: begin
                    if (cnt_tc_s) begin
                        state_nxt_s    = EXPOSE;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = cfg_exposure_r - CNT_ONE;
                    end else begin
                        state_nxt_s = RST;
                    end
                end
                EXPOSE: begin
                    if (cnt_tc_s) begin
                        state_nxt_s    = SAMPLE;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = CNT_W'(SAMPLE_LEN - 1);
                    end else begin
                        state_nxt_s = EXPOSE;
                    end
                end
                SAMPLE: begin
                    if (cnt_tc_s) begin
                        state_nxt_s = HOLD;
                        cnt_load_s  = 1'b1;
                    end else begin
                        state_nxt_s = SAMPLE;
                    end
                end
                HOLD, GAP: begin
                    // Both last one cycle and then open the next row.
                    if (cnt_tc_s) begin
                        state_nxt_s    = READOUT;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = cfg_readout_len_r - CNT_ONE;
                        row_nxt_s      = (state_r == HOLD) ? {ROW_W{1'b0}} : (row_r + ROW_ONE);
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                READOUT: begin
                    if (cnt_tc_s) begin
                        state_nxt_s = (row_r == ROW_LAST) ? DONE : GAP;
                        cnt_load_s  = 1'b1;
                    end else begin
                        state_nxt_s = READOUT;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_load_s  = 1'b1;
                end
            endcase
        end
    end

    // State, row index and latched frame configuration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= IDLE;
            row_r             <= {ROW_W{1'b0}};
            cfg_rst_len_r     <= CNT_ZERO;
            cfg_exposure_r    <= CNT_ZERO;
            cfg_readout_len_r <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            row_r   <= row_nxt_s;
            if (latch_s) begin
                cfg_rst_len_r     <= rst_len;
                cfg_exposure_r    <= exposure;
                cfg_readout_len_r <= readout_len;
            end else begin
                cfg_rst_len_r     <= cfg_rst_len_r;
                cfg_exposure_r    <= cfg_exposure_r;
                cfg_readout_len_r <= cfg_readout_len_r;
            end
        end
    end

    // On the latching edge the registered length is not yet valid.
    assign rst_len_eff_s = latch_s ? rst_len : cfg_rst_len_r;

    // One-hot row decode for the upcoming cycle.
    always_comb begin
        row_select_nxt_s = {NUM_ROWS{1'b0}};
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_select_nxt_s[r] = (state_nxt_s == READOUT) && (row_nxt_s == ROW_W'(r));
        end
    end

    // Registered strobes. The phase counter runs down, so a count of
    // length-1 is the first cycle of a phase and 0 is the last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vrst_sel0  <= IDLE_VRST_SEL0;
            pixel_rst  <= IDLE_PIXEL_RST;
            precharge  <= IDLE_PRECHARGE;
            sample     <= IDLE_SAMPLE;
            mem_sel    <= IDLE_MEM_SEL;
            pulse      <= IDLE_PULSE;
            row_select <= {NUM_ROWS{1'b0}};
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            vrst_sel0  <= (state_nxt_s != RST);
            pixel_rst  <= (state_nxt_s == RST) && (cnt_nxt_s != CNT_ZERO) &&
                          (cnt_nxt_s != (rst_len_eff_s - CNT_ONE));
            // Cycle index exposure-PRE_LEAD counts down to PRE_LEAD-1.
            precharge  <= (state_nxt_s == EXPOSE) && (cnt_nxt_s == CNT_W'(PRE_LEAD - 1));
            sample     <= (state_nxt_s == SAMPLE);
            mem_sel    <= (state_nxt_s == RST) || (state_nxt_s == EXPOSE) ||
                          (state_nxt_s == SAMPLE);
            pulse      <= !((state_nxt_s == RST) || (state_nxt_s == EXPOSE) ||
                            (state_nxt_s == SAMPLE) || (state_nxt_s == HOLD));
            row_select <= row_select_nxt_s;
            busy       <= (state_nxt_s != IDLE);
            frame_done <= (state_nxt_s == DONE);
            cfg_err    <= cfg_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_camera_timing_seq.sv
// Directed bench for camera_timing_seq with NUM_ROWS=4, SAMPLE_LEN=10, PRE_LEAD=10.
// Outputs are captured on every falling edge into a trace indexed by cycle
// number relative to the edge that samples start (cycle 1 = first RST cycle).
module tb_camera_timing_seq;

    localparam int CNT_W = 14, NUM_ROWS = 4, SAMPLE_LEN = 10, PRE_LEAD = 10;
    localparam int TR = 512;
    localparam int B_BUSY = 0, B_PRE = 1, B_SAMP = 2, B_PIX = 3, B_DONE = 4;
    localparam int B_VRST = 5, B_MEM = 6, B_PULSE = 7, B_CERR = 8, B_ROW0 = 9;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, continuous = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] rst_len = '0, exposure = '0, readout_len = '0;
    logic vrst_sel0, pixel_rst, precharge, sample, mem_sel, pulse;
    logic [NUM_ROWS-1:0] row_select;
    logic busy, frame_done, cfg_err;

    camera_timing_seq #(.CNT_W(CNT_W), .NUM_ROWS(NUM_ROWS), .SAMPLE_LEN(SAMPLE_LEN),
                        .PRE_LEAD(PRE_LEAD)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
        .rst_len(rst_len), .exposure(exposure), .readout_len(readout_len),
        .vrst_sel0(vrst_sel0), .pixel_rst(pixel_rst), .precharge(precharge),
        .sample(sample), .mem_sel(mem_sel), .pulse(pulse), .row_select(row_select),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rl; int ex; int rd; bit valid;
        int total; int pre; int samp_first; int samp_last;
    } vec_t;
    vec_t vec [0:5];

    logic [12:0] trace [0:TR-1];
    int cyc = 0;
    int base = -100000;
    int n_checks = 0;
    int n_pass = 0;

    // Trace capture away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if ((cyc + 1 - base >= 0) && (cyc + 1 - base < TR))
            trace[cyc + 1 - base] <= {row_select, cfg_err, pulse, mem_sel, vrst_sel0,
                                      frame_done, pixel_rst, sample, precharge, busy};
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    function automatic int count_hi(input int b, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (trace[c][b]) n++;
        return n;
    endfunction

    function automatic int first_hi(input int b, input int lo, input int hi);
        for (int c = lo; c <= hi; c++) if (trace[c][b]) return c;
        return -1;
    endfunction

    function automatic int last_hi(input int b, input int lo, input int hi);
        for (int c = hi; c >= lo; c--) if (trace[c][b]) return c;
        return -1;
    endfunction

    // Applies config and a one-cycle start; returns during cycle 1.
    task automatic start_frame(input int rl, input int ex, input int rd, input logic cont);
        @(negedge clk); #1;
        rst_len = CNT_W'(rl); exposure = CNT_W'(ex); readout_len = CNT_W'(rd);
        continuous = cont; start = 1'b1; base = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_vector(input int i);
        vec_t v;
        int win, rows_first, rows_last, zeros;
        string p;
        v = vec[i];
        p = $sformatf("v%0d", i);
        start_frame(v.rl, v.ex, v.rd, 1'b0);
        // Later input changes must not disturb the frame in flight.
        rst_len = CNT_W'(5); exposure = CNT_W'(50); readout_len = CNT_W'(7);
        win = v.valid ? v.total + 4 : 4;
        for (int c = 2; c <= win; c++) begin
            @(negedge clk); #1;
            start = (v.valid && (c == v.total / 2)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        if (!v.valid) begin
            check({p, " cfg_err_c1"}, int'(trace[1][B_CERR]), 1);
            check({p, " cfg_err_cnt"}, count_hi(B_CERR, 1, win), 1);
            check({p, " busy_cnt"}, count_hi(B_BUSY, 1, win), 0);
        end else begin
            check({p, " busy_cnt"}, count_hi(B_BUSY, 1, win), v.total);
            check({p, " busy_first"}, first_hi(B_BUSY, 1, win), 1);
            check({p, " precharge_cnt"}, count_hi(B_PRE, 1, win), 1);
            check({p, " precharge_cyc"}, first_hi(B_PRE, 1, win), v.pre);
            check({p, " sample_first"}, first_hi(B_SAMP, 1, win), v.samp_first);
            check({p, " sample_last"}, last_hi(B_SAMP, 1, win), v.samp_last);
            check({p, " pixel_rst_first"}, first_hi(B_PIX, 1, win), 2);
            check({p, " pixel_rst_last"}, last_hi(B_PIX, 1, win), v.rl - 1);
            check({p, " pixel_rst_cnt"}, count_hi(B_PIX, 1, win), v.rl - 2);
            check({p, " frame_done_cnt"}, count_hi(B_DONE, 1, win), 1);
            check({p, " frame_done_cyc"}, first_hi(B_DONE, 1, win), v.total);
            check({p, " vrst_low_cnt"}, win - count_hi(B_VRST, 1, win), v.rl);
            check({p, " mem_sel_cnt"}, count_hi(B_MEM, 1, win), v.rl + v.ex + SAMPLE_LEN);
            check({p, " pulse_low_cnt"}, win - count_hi(B_PULSE, 1, win),
                  v.rl + v.ex + SAMPLE_LEN + 1);
            check({p, " cfg_err_cnt"}, count_hi(B_CERR, 1, win), 0);
            for (int r = 0; r < NUM_ROWS; r++) begin
                check($sformatf("%s row%0d_first", p, r), first_hi(B_ROW0 + r, 1, win),
                      v.rl + v.ex + SAMPLE_LEN + 2 + r * (v.rd + 1));
                check($sformatf("%s row%0d_cnt", p, r), count_hi(B_ROW0 + r, 1, win), v.rd);
            end
            rows_first = first_hi(B_ROW0, 1, win);
            rows_last  = last_hi(B_ROW0 + NUM_ROWS - 1, 1, win);
            zeros = 0;
            for (int c = rows_first; c <= rows_last; c++) begin
                if (trace[c][B_ROW0 +: NUM_ROWS] == 4'b0000) zeros++;
                if ($countones(trace[c][B_ROW0 +: NUM_ROWS]) > 1) zeros += 100;
            end
            check({p, " row_gaps"}, zeros, NUM_ROWS - 1);
        end
    endtask

    initial begin
        // rst_len, exposure, readout_len, valid, busy cycles, precharge, sample span
        vec[0] = '{11, 100, 20, 1'b1, 206, 102, 112, 121};
        vec[1] = '{3, 11, 1, 1'b1, 33, 5, 15, 24};
        vec[2] = '{5, 20, 3, 1'b1, 52, 16, 26, 35};
        vec[3] = '{2, 100, 20, 1'b0, 0, 0, 0, 0};
        vec[4] = '{11, 10, 20, 1'b0, 0, 0, 0, 0};
        vec[5] = '{11, 100, 0, 1'b0, 0, 0, 0, 0};

        #12;
        check("reset vrst_sel0", int'(vrst_sel0), 1);
        check("reset pulse", int'(pulse), 1);
        check("reset busy", int'(busy), 0);
        check("reset others", int'({pixel_rst, precharge, sample, mem_sel, row_select,
                                    frame_done, cfg_err}), 0);
        @(negedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vector(i);

        // Back-to-back frames; exposure change lands in the second frame only.
        start_frame(11, 100, 20, 1'b1);
        for (int c = 2; c <= 370; c++) begin
            @(negedge clk); #1;
            if (c == 50) exposure = CNT_W'(50);
            if (c == 210) continuous = 1'b0;
        end
        check("cont done_cnt", count_hi(B_DONE, 1, 370), 2);
        check("cont done1", first_hi(B_DONE, 1, 370), 206);
        check("cont done2", last_hi(B_DONE, 1, 370), 362);
        check("cont busy_cnt", count_hi(B_BUSY, 1, 370), 362);
        check("cont rst2_c207", int'(trace[207][B_VRST]), 0);
        check("cont pre1", first_hi(B_PRE, 1, 370), 102);
        check("cont pre2", last_hi(B_PRE, 1, 370), 258);
        check("cont sample2_first", first_hi(B_SAMP, 207, 370), 268);

        // Abort while row 2 is selected (row 2 spans cycles 165-184).
        start_frame(11, 100, 20, 1'b0);
        for (int c = 2; c <= 200; c++) begin
            @(negedge clk); #1;
            abort = (c == 170) ? 1'b1 : 1'b0;
        end
        check("abort row2_before", int'(trace[170][B_ROW0 + 2]), 1);
        check("abort rows_after", int'(trace[171][B_ROW0 +: NUM_ROWS]), 0);
        check("abort pulse_after", int'(trace[171][B_PULSE]), 1);
        check("abort vrst_after", int'(trace[171][B_VRST]), 1);
        check("abort busy_after", count_hi(B_BUSY, 171, 200), 0);
        check("abort no_done", count_hi(B_DONE, 1, 200), 0);

        // Asynchronous reset in the middle of exposure, away from any edge.
        start_frame(11, 100, 20, 1'b0);
        for (int c = 2; c <= 50; c++) begin
            @(negedge clk); #1;
        end
        check("areset mem_sel_before", int'(mem_sel), 1);
        #2 reset = 1'b1;
        #1;
        check("areset busy", int'(busy), 0);
        check("areset vrst_sel0", int'(vrst_sel0), 1);
        check("areset pulse", int'(pulse), 1);
        check("areset mem_sel", int'(mem_sel), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        run_vector(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/camera_timing_seq.md
CAMERA_TIMING_SEQ -- requirements
Module: camera_timing_seq

Interface
REQ-001 SHALL have parameters: CNT_W (default 14, timing-field width); NUM_ROWS (default 8, rows scanned per frame); SAMPLE_LEN (default 10, sample phase cycles); PRE_LEAD (default 10, precharge lead before exposure end).
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  frame request; sampled only in IDLE.
REQ-005 continuous  in  1  1: back-to-back frames; 0: single frame.
REQ-006 abort  in  1  synchronous stop; return to IDLE.
REQ-007 rst_len  in  CNT_W  reset phase length in cycles.
REQ-008 exposure  in  CNT_W  exposure phase length in cycles.
REQ-009 readout_len  in  CNT_W  row_select high time per row in cycles.
REQ-010 vrst_sel0, pixel_rst, precharge, sample, mem_sel, pulse  out  1 each  pixel control strobes.
REQ-011 row_select  out  NUM_ROWS  one-hot row enable.
REQ-012 busy  out  1; frame_done  out  1 (1-cycle pulse); cfg_err  out  1 (1-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, RST, EXPOSE, SAMPLE, HOLD, READOUT, GAP, DONE.
REQ-014 IDLE->RST on start with valid config; rst_len, exposure and readout_len latched at that edge; later input changes have no effect on the current frame.
REQ-015 Config invalid if rst_len<3, exposure<=PRE_LEAD or readout_len==0; start with invalid config: remain IDLE, cfg_err=1 for one cycle.
REQ-016 Phase lengths: RST=rst_len, EXPOSE=exposure, SAMPLE=SAMPLE_LEN, HOLD=1, GAP=1, DONE=1 cycles.
REQ-017 READOUT visits rows 0..NUM_ROWS-1 in order, each readout_len cycles; one GAP cycle between consecutive rows only, none after the last row.
REQ-018 All outputs registered; the first RST output cycle is the cycle after start is sampled.
REQ-019 vrst_sel0=0 throughout RST, else 1.
REQ-020 pixel_rst=1 in RST except its first and last cycle, else 0.
REQ-021 precharge=1 only on EXPOSE cycle index exposure-PRE_LEAD (0-based).
REQ-022 sample=1 throughout SAMPLE, else 0.
REQ-023 mem_sel=1 in RST, EXPOSE and SAMPLE; pulse=0 in RST, EXPOSE, SAMPLE and HOLD, else 1.
REQ-024 row_select[r]=1 only during READOUT of row r; all zero in GAP and all other states.
REQ-025 busy=1 in every state except IDLE; frame_done=1 only in DONE.
REQ-026 From DONE: if continuous=1, go to RST, relatching config (invalid config -> IDLE with cfg_err); else go to IDLE.
REQ-027 abort in any non-IDLE state: IDLE and idle output levels on the next cycle; no frame_done; abort takes priority over every transition.
REQ-028 start while busy SHALL be ignored.
REQ-029 Phase counters SHALL be CNT_W bits, never wrap; terminal count SHALL be detected at length-1.

Reset
REQ-030 On reset: state IDLE; vrst_sel0=1, pulse=1; all other outputs 0; latched config 0.
REQ-031 Reset asserted mid-frame SHALL force idle levels immediately, without waiting for a clock edge.

Structure
REQ-032 Package camera_timing_pkg SHALL hold the state enumeration, idle output levels and minimum-length constants.
REQ-033 A single sub-module, phase_counter (loadable down counter with terminal flag), SHALL time every phase.

Verification (NUM_ROWS=4, SAMPLE_LEN=10, PRE_LEAD=10)
REQ-034 rst_len=11, exposure=100, readout_len=20, start pulse, continuous=0 -> busy for 206 cycles; precharge on cycle 102; sample on cycles 112-121; frame_done on cycle 206; then IDLE.
REQ-035 Same config -> pixel_rst high on cycles 2-10; row_select one-hot 1,2,4,8 for 20 cycles each, separated by 1-cycle zero gaps.
REQ-036 rst_len=2, start -> cfg_err for 1 cycle; busy stays 0.
REQ-037 continuous=1 -> second frame's RST starts the cycle after frame_done; changing exposure to 50 mid-frame affects the second frame only.
REQ-038 abort during READOUT row 2 -> next cycle row_select=0, pulse=1, busy=0, no frame_done.
REQ-039 Async reset asserted during EXPOSE, between clock edges -> idle levels immediately; start after release -> normal frame.
